mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences all accesses to the single shared 32-bit memory bank.
- Three requesters share the bank:
  - loader port: program image load, write only;
  - data port: load/store from the CPU datapath;
  - fetch port: instruction fetch, read only.
- Serialises requests onto one memory handshake, applies fixed/round-robin priority, and bounds every access with a timeout.

Parameters:
- AW, 12: word address width (4096-word bank).
- TIMEOUT, 16: maximum BUSY cycles to wait for mem_rdy before an access fails; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- l_req  in  1  loader request (level).
- l_addr  in  AW  loader word address.
- l_wdata  in  32  loader write data.
- l_ack  out  1  loader completion pulse.
- d_req  in  1  data request (level).
- d_wen  in  1  data write enable (1 = store).
- d_addr  in  AW  data word address.
- d_wdata  in  32  store data.
- d_ack  out  1  data completion pulse.
- f_req  in  1  fetch request (level).
- f_addr  in  AW  fetch word address.
- f_ack  out  1  fetch completion pulse.
- rdata  out  32  read data, shared by all requesters; valid while the matching ack is high.
- err  out  1  timeout flag; valid while an ack is high.
- busy  out  1  high in BUSY and RESP.
- grant  out  2  current owner: 00 none, 01 fetch, 10 data, 11 loader.
- mem_req  out  1  memory access request.
- mem_wen  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; sampled when mem_rdy=1.
- mem_rdy  in  1  memory completion; only meaningful during BUSY.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, timeout counter 0, round-robin bit last_dat=1 (so fetch wins the first data/fetch tie).
- Reset takes effect asynchronously and mid-operation: mem_req drops immediately, no ack is issued, and the aborted access is discarded.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, pick the winner at the clock edge.
  - Loader has absolute priority.
  - Data vs fetch: if only one is pending it wins. If both are pending, fetch wins when last_dat=1, data wins when last_dat=0.
  - Latch the winner's addr/wdata/wen into mem_addr/mem_wdata/mem_wen. Loader wen=1; fetch wen=0 and mem_wdata=0.
  - Set grant, mem_req=1, counter=0, go to BUSY.
  - Update last_dat only on data/fetch grants (1 after a data grant, 0 after a fetch grant).
- BUSY:
  - mem_req stays 1; addr, wdata and wen stay stable.
  - If mem_rdy=1: rdata<=mem_rdata for reads, 0 for writes; err<=0; mem_req<=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with mem_rdy=0: err<=1, rdata<=0, mem_req<=0, go to RESP.
  - mem_rdy=1 in the same cycle as the timeout counts as success.
- RESP:
  - Exactly one of l_ack/d_ack/f_ack, chosen by grant, is high for one cycle.
  - Next state is IDLE. grant<=00 and busy<=0 on exit.
  - rdata and err hold their values until the next RESP.
- Requester rules:
  - Hold req and payload stable until the ack cycle, and drop req at the edge ending the ack cycle. A req still high in the following IDLE cycle is a new request.
  - Payload changes after the grant edge are ignored.
- Latency: req sampled at edge E0 → BUSY. With mem_rdy in the first BUSY cycle, ack is high in the cycle after E1. Minimum 3 cycles per transaction; peak throughput is 1 access per 3 cycles.
- mem_rdy outside BUSY is ignored.
- Starvation: a continuously asserted l_req starves data and fetch by design, because the loader runs only before enable.

Test Plan:
- Fetch read: f_req=1, f_addr=0x010; memory returns mem_rdata=0xDEADBEEF with mem_rdy=1 in the first BUSY cycle → mem_addr=0x010, mem_wen=0, grant=01; f_ack high for exactly 1 cycle with rdata=0xDEADBEEF, err=0; transaction takes 3 cycles.
- Tie: d_req and f_req held high continuously, zero-wait memory → grant sequence 01,10,01,10 (fetch first after reset); d_ack and f_ack alternate.
- Loader priority: l_req, d_req and f_req all high; loader writes addr 0..3 with 0x11111111..0x44444444 → four loader grants (mem_wen=1) before any data/fetch grant; a fetch read of addr 2 afterwards returns 0x33333333.
- Data store then load: d_wen=1, addr 0x400, data 0x000000A5, then d_wen=0, addr 0x400 → two d_acks; the second has rdata=0x000000A5, err=0.
- Timeout: f_req with mem_rdy tied 0 → mem_req high for exactly 16 cycles; then f_ack with err=1, rdata=0, mem_req=0. Repeat with mem_rdy=1 on cycle 16 → err=0.
- Reset mid-BUSY: drive rst=0 on the 2nd BUSY cycle → mem_req, busy and grant go 0 before the next edge, and no ack occurs. After rst=1 with d_req still high → a fresh arbitration and normal d_ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-owner sequencer for the shared 32-bit memory bank.
//
// Requesters (level req, one-cycle ack pulse):
//   l_*  loader, write only, absolute priority
//   d_*  CPU data port, load (d_wen=0) or store (d_wen=1)
//   f_*  instruction fetch, read only
// Memory side: mem_req/mem_wen/mem_addr/mem_wdata out, mem_rdata/mem_rdy in.
// Status: rdata/err (valid with an ack, held until the next response),
//         busy, grant (00 none, 01 fetch, 10 data, 11 loader),
//         dbg_state (FSM state: 0 IDLE, 1 BUSY, 2 RESP).
//
// Handshakes: a requester raises req with a stable payload and keeps both
// until its ack cycle; the arbiter samples the winner in IDLE and ignores
// payload changes after that edge. On the memory side mem_req is held with
// a stable payload through BUSY; mem_rdy completes the access and is only
// looked at in BUSY. An access with no mem_rdy for TIMEOUT cycles completes
// with err=1 and rdata=0.
module mem_arbiter #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ack,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          busy,
  output logic [1:0]    grant,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rdy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_FETCH = 2'b01;
  localparam logic [1:0] G_DATA  = 2'b10;
  localparam logic [1:0] G_LOAD  = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic          last_dat_q;   // 1: data owned the bank last, fetch wins a tie
  logic [1:0]    grant_q;
  logic          busy_q;
  logic          mem_req_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          l_ack_q;
  logic          d_ack_q;
  logic          f_ack_q;
  logic [1:0]    win;

  // Winner among the current requests; only consumed in IDLE.
  always_comb begin
    win = G_NONE;
    if (l_req)               win = G_LOAD;
    else if (d_req && f_req) win = last_dat_q ? G_FETCH : G_DATA;
    else if (d_req)          win = G_DATA;
    else if (f_req)          win = G_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      last_dat_q  <= 1'b1;
      grant_q     <= G_NONE;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      l_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_ack_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win != G_NONE) begin
            grant_q   <= win;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= ST_BUSY;
            case (win)
              G_LOAD: begin
                mem_addr_q  <= l_addr;
                mem_wdata_q <= l_wdata;
                mem_wen_q   <= 1'b1;
              end
              G_DATA: begin
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
                mem_wen_q   <= d_wen;
                last_dat_q  <= 1'b1;
              end
              default: begin
                mem_addr_q  <= f_addr;
                mem_wdata_q <= 32'd0;
                mem_wen_q   <= 1'b0;
                last_dat_q  <= 1'b0;
              end
            endcase
          end
        end
        ST_BUSY: begin
          // mem_rdy is checked first so a late completion on the last
          // allowed cycle still counts as success.
          if (mem_rdy || (cnt_q == CNT_LAST)) begin
            rdata_q   <= (mem_rdy && !mem_wen_q) ? mem_rdata : 32'd0;
            err_q     <= !mem_rdy;
            mem_req_q <= 1'b0;
            l_ack_q   <= (grant_q == G_LOAD);
            d_ack_q   <= (grant_q == G_DATA);
            f_ack_q   <= (grant_q == G_FETCH);
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          l_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          f_ack_q <= 1'b0;
          grant_q <= G_NONE;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign l_ack     = l_ack_q;
  assign d_ack     = d_ack_q;
  assign f_ack     = f_ack_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// A memory responder with programmable wait/stuck behaviour sits on the
// memory port; requester agents replay per-port operation queues; a
// transaction-level model (arbitration rules + reference memory) predicts
// the grant order and every response, and a compare process checks the
// DUT outputs against it on each cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW      = 12;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          l_req = 1'b0, d_req = 1'b0, f_req = 1'b0, d_wen = 1'b0;
  logic [AW-1:0] l_addr = '0, d_addr = '0, f_addr = '0;
  logic [31:0]   l_wdata = '0, d_wdata = '0;
  logic          l_ack, d_ack, f_ack, err, busy, mem_req, mem_wen;
  logic [31:0]   rdata, mem_wdata;
  logic [1:0]    grant, dbg_state;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rdy = 1'b0;

  mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .rdata(rdata), .err(err), .busy(busy), .grant(grant),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] bank [4096];
  int mem_wait = 0;
  bit mem_stuck = 1'b0;
  int bcnt = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      bcnt++;
      if (!mem_stuck && bcnt == mem_wait + 1) begin
        mem_rdy = 1'b1;
        if (mem_wen) begin
          bank[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = bank[mem_addr];
        end
      end else begin
        mem_rdy = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      bcnt = 0;
      mem_rdy = 1'($urandom_range(0, 1));  // must be ignored outside BUSY
      mem_rdata = $urandom;
    end
  end

  // ---------------- requester agents ----------------
  // op = {wen, addr[11:0], wdata[31:0]}
  logic [44:0] l_q[$], d_q[$], f_q[$];

  always @(negedge clk) begin
    logic [44:0] t;
    if (l_ack && l_q.size() > 0) void'(l_q.pop_front());
    if (l_q.size() > 0) begin
      t = l_q[0];
      l_req = 1'b1; l_addr = t[43:32]; l_wdata = t[31:0];
    end else l_req = 1'b0;
  end

  always @(negedge clk) begin
    logic [44:0] t;
    if (d_ack && d_q.size() > 0) void'(d_q.pop_front());
    if (d_q.size() > 0) begin
      t = d_q[0];
      d_req = 1'b1; d_wen = t[44]; d_addr = t[43:32]; d_wdata = t[31:0];
    end else d_req = 1'b0;
  end

  always @(negedge clk) begin
    logic [44:0] t;
    if (f_ack && f_q.size() > 0) void'(f_q.pop_front());
    if (f_q.size() > 0) begin
      t = f_q[0];
      f_req = 1'b1; f_addr = t[43:32];
    end else f_req = 1'b0;
  end

  // ---------------- model + scoreboard ----------------
  logic [31:0] ref_mem [4096];
  logic [44:0] m_l[$], m_d[$], m_f[$];     // ops of the next burst
  bit          m_last_dat = 1'b1;
  logic [54:0] exp_g_q[$];                 // {grant, wen, addr, wdata, busy_len}
  logic [34:0] exp_q[$];                   // {port, err, rdata}

  // All ops of a burst are raised together and held until served, so the
  // service order follows directly from the priority rules.
  task automatic issue(input int len, input bit to, input bit drive);
    if (drive) begin
      foreach (m_l[i]) l_q.push_back(m_l[i]);
      foreach (m_d[i]) d_q.push_back(m_d[i]);
      foreach (m_f[i]) f_q.push_back(m_f[i]);
    end
    while (m_l.size() + m_d.size() + m_f.size() > 0) begin
      logic [1:0]  g;
      logic [44:0] o;
      if (m_l.size() > 0) begin
        g = 2'b11; o = m_l.pop_front();
      end else if (m_d.size() > 0 && (m_f.size() == 0 || !m_last_dat)) begin
        g = 2'b10; o = m_d.pop_front(); m_last_dat = 1'b1;
      end else begin
        g = 2'b01; o = m_f.pop_front(); m_last_dat = 1'b0;
      end
      exp_g_q.push_back({g, o, 8'(len)});
      if (to) exp_q.push_back({g, 1'b1, 32'h0});
      else if (o[44]) begin
        ref_mem[o[43:32]] = o[31:0];
        exp_q.push_back({g, 1'b0, 32'h0});
      end else exp_q.push_back({g, 1'b0, ref_mem[o[43:32]]});
    end
  endtask

  // ---------------- compare process ----------------
  int          cyc = 0;
  logic        prev_req = 1'b0;
  int          req_len = 0;
  int          len_exp = 0;
  logic [54:0] cur_g = '0;
  logic [31:0] hold_rdata = '0;
  logic        hold_err = 1'b0;
  int          last_grant_cyc = -1;
  bit          b2b = 1'b0;

  always @(negedge clk) begin
    logic [54:0] ge;
    logic [34:0] ae;
    logic [1:0]  ack_port;
    int          nack;
    if (!rst) begin
      chk("ack_in_reset", {61'd0, l_ack, d_ack, f_ack}, 64'd0);
      prev_req = 1'b0; req_len = 0; hold_rdata = '0; hold_err = 1'b0;
      last_grant_cyc = -1;
    end else begin
      cyc++;
      nack = int'(l_ack) + int'(d_ack) + int'(f_ack);
      chk("ack_onehot", 64'(nack <= 1), 64'd1);
      chk("busy", busy, 64'(mem_req || nack != 0));
      chk("grant_vs_busy", 64'(grant != 2'b00), busy);
      if (mem_req && !prev_req) begin
        chk("grant_expected", 64'(exp_g_q.size() > 0), 64'd1);
        if (exp_g_q.size() > 0) begin
          ge = exp_g_q.pop_front();
          cur_g = ge;
          chk("grant", grant, ge[54:53]);
          chk("mem_wen", mem_wen, ge[52]);
          chk("mem_addr", mem_addr, ge[51:40]);
          chk("mem_wdata", mem_wdata, ge[39:8]);
          len_exp = int'(ge[7:0]);
          if (b2b && last_grant_cyc >= 0) chk("grant_spacing", 64'(cyc - last_grant_cyc), 64'd3);
          last_grant_cyc = cyc;
        end
        req_len = 0;
      end else if (mem_req) begin
        chk("payload_stable", {grant, mem_wen, mem_addr, mem_wdata}, cur_g[54:8]);
      end
      if (mem_req) req_len++;
      if (!mem_req && prev_req) begin
        chk("mem_req_len", 64'(req_len), 64'(len_exp));
        chk("ack_after_busy", 64'(nack), 64'd1);
      end
      if (nack != 0) begin
        ack_port = l_ack ? 2'b11 : (d_ack ? 2'b10 : 2'b01);
        chk("ack_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          ae = exp_q.pop_front();
          chk("ack_port", ack_port, ae[34:33]);
          chk("ack_grant", grant, ae[34:33]);
          chk("err", err, ae[32]);
          chk("rdata", rdata, ae[31:0]);
        end
        hold_rdata = rdata; hold_err = err;
      end else begin
        chk("rdata_hold", rdata, hold_rdata);
        chk("err_hold", err, hold_err);
      end
      prev_req = mem_req;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_q.size() > 0 || l_q.size() > 0 || d_q.size() > 0 || f_q.size() > 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_done"}, 64'(exp_q.size() + l_q.size() + d_q.size() + f_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_burst();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int guard;
    for (int i = 0; i < 4096; i++) begin
      bank[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = bank[i];
    end
    bank[12'h010] = 32'hDEAD_BEEF;
    ref_mem[12'h010] = 32'hDEAD_BEEF;

    // Reset values
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_l_ack", l_ack, 0);       chk("rst_d_ack", d_ack, 0);
    chk("rst_f_ack", f_ack, 0);       chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);           chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);       chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wen", mem_wen, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0); chk("rst_state", dbg_state, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    m_last_dat = 1'b1;

    // Tie: fetch first after reset, then strict alternation, 3 cycles apart
    start_burst();
    last_grant_cyc = -1; b2b = 1'b1;
    m_d.push_back({1'b0, 12'h020, 32'h0BAD_0020});
    m_d.push_back({1'b0, 12'h021, 32'h0BAD_0021});
    m_f.push_back({1'b0, 12'h030, 32'h0});
    m_f.push_back({1'b0, 12'h031, 32'h0});
    issue(1, 1'b0, 1'b1);
    wait_done("tie");
    b2b = 1'b0;

    // Fetch read
    start_burst();
    m_f.push_back({1'b0, 12'h010, 32'h0});
    issue(1, 1'b0, 1'b1);
    wait_done("fetch");
    chk("fetch_rdata_pin", rdata, 32'hDEAD_BEEF);
    chk("fetch_err_pin", err, 0);

    // Loader priority over pending data and fetch
    start_burst();
    m_l.push_back({1'b1, 12'h000, 32'h1111_1111});
    m_l.push_back({1'b1, 12'h001, 32'h2222_2222});
    m_l.push_back({1'b1, 12'h002, 32'h3333_3333});
    m_l.push_back({1'b1, 12'h003, 32'h4444_4444});
    m_d.push_back({1'b0, 12'h005, 32'hCAFE_0000});
    m_f.push_back({1'b0, 12'h002, 32'h0});
    issue(1, 1'b0, 1'b1);
    wait_done("loader");
    chk("loader_readback_pin", rdata, 32'h3333_3333);

    // Data store then load, memory with 2 wait cycles
    mem_wait = 2;
    start_burst();
    m_d.push_back({1'b1, 12'h400, 32'h0000_00A5});
    m_d.push_back({1'b0, 12'h400, 32'h0});
    issue(3, 1'b0, 1'b1);
    wait_done("store_load");
    chk("store_load_pin", rdata, 32'h0000_00A5);
    mem_wait = 0;

    // Timeout, then completion on the last allowed cycle
    mem_stuck = 1'b1;
    start_burst();
    m_f.push_back({1'b0, 12'h010, 32'h0});
    issue(TIMEOUT, 1'b1, 1'b1);
    wait_done("timeout");
    chk("timeout_err_pin", err, 1);
    chk("timeout_rdata_pin", rdata, 0);
    chk("timeout_mem_req", mem_req, 0);
    mem_stuck = 1'b0;
    mem_wait = TIMEOUT - 1;
    start_burst();
    m_f.push_back({1'b0, 12'h010, 32'h0});
    issue(TIMEOUT, 1'b0, 1'b1);
    wait_done("late_rdy");
    chk("late_rdy_err_pin", err, 0);
    chk("late_rdy_rdata_pin", rdata, 32'hDEAD_BEEF);
    mem_wait = 0;

    // Reset on the 2nd BUSY cycle aborts the access without an ack
    mem_stuck = 1'b1;
    start_burst();
    d_q.push_back({1'b0, 12'h020, 32'h0});
    exp_g_q.push_back({2'b10, 1'b0, 12'h020, 32'h0, 8'd0});
    n = 0; guard = 0;
    while (n < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (mem_req) n++;
    end
    chk("reach_busy2", 64'(n), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 0);
    chk("abort_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    mem_stuck = 1'b0;
    m_last_dat = 1'b1;
    m_d.push_back({1'b0, 12'h020, 32'h0});
    issue(1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    wait_done("after_reset");
    chk("after_reset_rdata_pin", rdata, 32'hA500_0020);

    chk("grant_q_drained", 64'(exp_g_q.size()), 64'd0);
    chk("ack_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
